// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register:
// shift mode codes and burst FSM state encodings.
package shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_SAR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational one-step shift function shared by single-step and burst paths.
// Rotates exist only when USR_ROTATE_EN is defined; otherwise ROL/ROR fall back to SHL/SHR.
module shift_step
    import shift_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] q,
    input  logic [2:0]    mode,
    input  logic          sin_l,
    input  logic          sin_r,
    output logic [DW-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_SHL: q_next = {q[DW-2:0], sin_l};
            MODE_SHR: q_next = {sin_r, q[DW-1:1]};
            MODE_SAR: q_next = {q[DW-1], q[DW-1:1]};
`ifdef USR_ROTATE_EN
            MODE_ROL: q_next = {q[DW-2:0], q[DW-1]};
            MODE_ROR: q_next = {q[0], q[DW-1:1]};
`else
            MODE_ROL: q_next = {q[DW-2:0], sin_l};
            MODE_ROR: q_next = {sin_r, q[DW-1:1]};
`endif
            default:  q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, single-step shifts and an
// auto-shift burst engine. Optional rotate modes: define USR_ROTATE_EN.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int DW   = 8,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            sync_rst_n,
    input  logic            load,
    input  logic            en,
    input  logic [2:0]      mode,
    input  logic [DW-1:0]   data,
    input  logic            sin_l,
    input  logic            sin_r,
    input  logic            burst_start,
    input  logic [CNTW-1:0] burst_len,
    output logic [DW-1:0]   q,
    output logic            sout_l,
    output logic            sout_r,
    output logic            busy,
    output logic            done
);

    state_e          state_q, state_d;
    logic [DW-1:0]   q_q, q_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [2:0]      mode_r_q, mode_r_d;
    logic [2:0]      step_mode;
    logic [DW-1:0]   q_step;
    logic            last_step;

    assign last_step = (count_q == CNTW'(1));

    // Burst uses the mode latched at start; single steps use the live input.
    assign step_mode = (state_q == ST_BURST) ? mode_r_q : mode;

    shift_step #(
        .DW (DW)
    ) u_step (
        .q      (q_q),
        .mode   (step_mode),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_next (q_step)
    );

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!load && burst_start) begin
                    state_d = (burst_len != '0) ? ST_BURST : ST_DONE;
                end
            end
            ST_BURST: begin
                if (load) begin
                    state_d = ST_IDLE;
                end else if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        q_d      = q_q;
        count_d  = count_q;
        mode_r_d = mode_r_q;
        if (load) begin
            q_d = data;
        end else begin
            case (state_q)
                ST_BURST: begin
                    q_d     = q_step;
                    count_d = count_q - CNTW'(1);
                end
                ST_IDLE: begin
                    if (burst_start) begin
                        if (burst_len != '0) begin
                            mode_r_d = mode;
                            count_d  = burst_len;
                        end
                    end else if (en) begin
                        q_d = q_step;
                    end
                end
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            q_q      <= '0;
            count_q  <= '0;
            mode_r_q <= MODE_HOLD;
        end else begin
            q_q      <= q_d;
            count_q  <= count_d;
            mode_r_q <= mode_r_d;
        end
    end

    always_comb begin
        busy = (state_q == ST_BURST);
        done = (state_q == ST_DONE);
    end

    assign q      = q_q;
    assign sout_l = q_q[DW-1];
    assign sout_r = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (DW=8, CNTW=4).
// Expected values are queued when stimulus is driven and checked after the edge.
module tb_univ_shift_reg;

`ifdef USR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sync_rst_n;
    logic       load;
    logic       en;
    logic [2:0] mode;
    logic [7:0] data;
    logic       sin_l;
    logic       sin_r;
    logic       burst_start;
    logic [3:0] burst_len;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    univ_shift_reg #(
        .DW   (8),
        .CNTW (4)
    ) dut (
        .clk         (clk),
        .sync_rst_n  (sync_rst_n),
        .load        (load),
        .en          (en),
        .mode        (mode),
        .data        (data),
        .sin_l       (sin_l),
        .sin_r       (sin_r),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .q           (q),
        .sout_l      (sout_l),
        .sout_r      (sout_r),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic e, input logic [2:0] md,
                         input logic [7:0] d, input logic bs,
                         input logic [3:0] bl);
        load        = ld;
        en          = e;
        mode        = md;
        data        = d;
        burst_start = bs;
        burst_len   = bl;
    endtask

    task automatic tick(input string tag, input logic [7:0] eq,
                        input logic eb, input logic ed);
        exp_t e;
        e.tag  = tag;
        e.q    = eq;
        e.busy = eb;
        e.done = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".q"}, 32'(q), 32'(e.q));
            chk({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
            chk({e.tag, ".done"}, 32'(done), 32'(e.done));
            chk({e.tag, ".sout_l"}, 32'(sout_l), 32'(e.q[7]));
            chk({e.tag, ".sout_r"}, 32'(sout_r), 32'(e.q[0]));
        end
    endtask

    initial begin
        sync_rst_n = 1'b0;
        sin_l      = 1'b0;
        sin_r      = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 8'hFF, 1'b0, 4'd0);
        tick("reset", 8'h00, 1'b0, 1'b0);
        sync_rst_n = 1'b1;

        drive(1'b1, 1'b0, 3'b000, 8'hA5, 1'b0, 4'd0);
        tick("load_a5", 8'hA5, 1'b0, 1'b0);
        sin_l = 1'b1;
        drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 4'd0);
        tick("shl", 8'h4B, 1'b0, 1'b0);
        sin_r = 1'b0;
        drive(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 4'd0);
        tick("shr", 8'h25, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'b001, 8'h00, 1'b0, 4'd0);
        tick("en_low", 8'h25, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 4'd0);
        tick("hold0", 8'h25, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 3'b000, 8'h96, 1'b0, 4'd0);
        tick("load_96", 8'h96, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 4'd0);
        tick("sar1", 8'hCB, 1'b0, 1'b0);
        tick("sar2", 8'hE5, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 4'd0);
        tick("hold6", 8'hE5, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 3'b000, 8'h81, 1'b0, 4'd0);
        tick("load_81r", 8'h81, 1'b0, 1'b0);
        sin_r = 1'b0;
        drive(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 4'd0);
        tick("ror", ROT ? 8'hC0 : 8'h40, 1'b0, 1'b0);

        sin_l = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 8'h81, 1'b0, 4'd0);
        tick("load_81", 8'h81, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'b100, 8'h00, 1'b1, 4'd3);
        tick("b3_start", 8'h81, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 4'd0);
        tick("b3_s1", ROT ? 8'h03 : 8'h02, 1'b1, 1'b0);
        tick("b3_s2", ROT ? 8'h06 : 8'h04, 1'b1, 1'b0);
        tick("b3_s3", ROT ? 8'h0C : 8'h08, 1'b0, 1'b1);
        tick("b3_idle", ROT ? 8'h0C : 8'h08, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 3'b000, 8'h01, 1'b0, 4'd0);
        tick("load_01", 8'h01, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'b001, 8'h00, 1'b1, 4'd5);
        tick("b5_start", 8'h01, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 4'd0);
        tick("b5_s1", 8'h02, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 3'b000, 8'h3C, 1'b0, 4'd0);
        tick("b5_abort", 8'h3C, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 4'd0);
        tick("b5_nodone", 8'h3C, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'b001, 8'h00, 1'b1, 4'd0);
        tick("b0_done", 8'h3C, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 4'd0);
        tick("b0_idle", 8'h3C, 1'b0, 1'b0);

        sin_l = 1'b1;
        drive(1'b1, 1'b0, 3'b000, 8'h55, 1'b0, 4'd0);
        tick("load_55", 8'h55, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'b001, 8'h00, 1'b1, 4'd4);
        tick("b4_start", 8'h55, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 4'd1);
        tick("b4_ignore", 8'hAB, 1'b1, 1'b0);
        sync_rst_n = 1'b0;
        tick("b4_reset", 8'h00, 1'b0, 1'b0);
        sync_rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 4'd0);
        tick("b4_idle", 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
